fetch_unit: RTL and testbench

//  - RV32I instruction-fetch stage: owns the PC, drives the instruction ROM address, and registers the returned word into the IF/ID pipeline register.
//  - Sits directly upstream of the instruction ROM (combinational read, word index = pc>>2) and feeds the decoder.
//  - Selects next PC from sequential, branch/jump redirect, trap entry (utvec) and uret return (uepc); supports stall, flush and ebreak halt.

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 35 +++
 rtl/fetch_unit_if_id_reg.sv | 53 +++++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared RV32I fetch constants, FSM state encoding and PC helpers
package fetch_unit_pkg;

    localparam int PC_W = 16;
    localparam logic [PC_W-1:0] RESET_PC_DEF = '0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] addr);
        return addr & ~PC_W'(3);
    endfunction

    function automatic logic [PC_W-1:0] pc_next_seq(input logic [PC_W-1:0] addr);
        return addr + PC_W'(4);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: ROM address/data, pipeline control and IF/ID outputs
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic [PC_W-1:0] pc_o;
    logic [31:0]     rom_instr_i;
    logic            stall_i;
    logic            redirect_i;
    logic [PC_W-1:0] target_i;
    logic            trap_i;
    logic [PC_W-1:0] trap_vec_i;
    logic            uret_i;
    logic [PC_W-1:0] epc_i;
    logic            halt_i;
    logic            resume_i;
    logic [31:0]     id_instr_o;
    logic [PC_W-1:0] id_pc_o;
    logic            id_valid_o;
    logic            halted_o;
    logic            misalign_o;
    logic [PC_W-1:0] bad_addr_o;

    modport master (
        output pc_o, id_instr_o, id_pc_o, id_valid_o, halted_o, misalign_o, bad_addr_o,
        input  rom_instr_i, stall_i, redirect_i, target_i, trap_i, trap_vec_i,
               uret_i, epc_i, halt_i, resume_i
    );

    modport slave (
        input  pc_o, id_instr_o, id_pc_o, id_valid_o, halted_o, misalign_o, bad_addr_o,
        output rom_instr_i, stall_i, redirect_i, target_i, trap_i, trap_vec_i,
               uret_i, epc_i, halt_i, resume_i
    );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// rtl/fetch_unit_if_id_reg.sv - IF/ID pipeline register with load, hold and flush-to-bubble
module if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic [31:0]     instr_i,
    input  logic [PC_W-1:0] pc_i,
    output logic [31:0]     instr_o,
    output logic [PC_W-1:0] pc_o,
    output logic            valid_o
);

    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;

    // A bubble keeps the old PC; only the instruction and valid bit matter downstream.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d = instr_i;
            pc_d    = pc_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage (PC, next-PC select, BOOT/RUN/HALT FSM); FETCH_MISALIGN_TRAP_EN enables misaligned-target reporting
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = fetch_unit_pkg::RESET_PC_DEF,
    parameter logic [31:0]     NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;
    logic [PC_W-1:0] bad_addr_q, bad_addr_d;
    logic            ifid_load, ifid_flush;
    logic [PC_W-1:0] flow_tgt, flow_pc;
    logic            flow_bad;

    // uret and redirect share one target path; uret outranks redirect.
    always_comb begin
        flow_tgt = bus.uret_i ? bus.epc_i : bus.target_i;
        flow_bad = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        flow_pc  = flow_tgt;
        flow_bad = (flow_tgt[1:0] != 2'b00);
`else
        flow_pc  = pc_align(flow_tgt);
`endif
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        misalign_d = 1'b0;
        bad_addr_d = '0;
        if (bus.trap_i) begin
            pc_d       = bus.trap_vec_i;
            ifid_flush = 1'b1;
            state_d    = RUN;
        end else if (bus.uret_i || bus.redirect_i) begin
            ifid_flush = 1'b1;
            state_d    = (state_q == HALT) ? HALT : RUN;
            if (flow_bad) begin
                misalign_d = 1'b1;
                bad_addr_d = flow_tgt;
            end else begin
                pc_d = flow_pc;
            end
        end else begin
            unique case (state_q)
                BOOT: begin
                    state_d    = RUN;
                    ifid_flush = 1'b1;
                end
                HALT: begin
                    if (bus.resume_i) begin
                        state_d = RUN;
                        if (!bus.stall_i) begin
                            pc_d      = pc_next_seq(pc_q);
                            ifid_load = 1'b1;
                        end
                    end else begin
                        ifid_flush = 1'b1;
                    end
                end
                default: begin
                    // The word at pc_q is not consumed on the halting edge, so resume refetches it.
                    if (bus.halt_i) begin
                        state_d    = HALT;
                        ifid_flush = 1'b1;
                    end else if (!bus.stall_i) begin
                        pc_d      = pc_next_seq(pc_q);
                        ifid_load = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .instr_i (bus.rom_instr_i),
        .pc_i    (pc_q),
        .instr_o (bus.id_instr_o),
        .pc_o    (bus.id_pc_o),
        .valid_o (bus.id_valid_o)
    );

    assign bus.pc_o       = pc_q;
    assign bus.halted_o   = (state_q == HALT);
    assign bus.misalign_o = misalign_q;
    assign bus.bad_addr_o = bad_addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit: directed fetch, stall, flush, halt, wrap and reset cases
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    typedef struct {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } exp_t;

    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [PC_W-1:0] exp_pc;
    logic            prev_valid = 1'b0;
    logic [PC_W-1:0] prev_pc = '0;
    logic [31:0]     prev_instr = '0;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] rom_word(input logic [PC_W-1:0] a);
        return {16'hC0DE, a};
    endfunction

    assign bus.rom_instr_i = rom_word(bus.pc_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // Monitor: a new IF/ID presentation is a valid word differing from the one held last cycle.
    always @(negedge clk) begin
        if (bus.id_valid_o && !(prev_valid && bus.id_pc_o == prev_pc && bus.id_instr_o == prev_instr)) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL id_word: got instr %h pc %h, none expected", bus.id_instr_o, bus.id_pc_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.id_instr_o !== mon_e.instr || bus.id_pc_o !== mon_e.pc) begin
                    fails++;
                    $display("FAIL id_word: got instr %h pc %h expected instr %h pc %h",
                             bus.id_instr_o, bus.id_pc_o, mon_e.instr, mon_e.pc);
                end
            end
        end
        prev_valid = bus.id_valid_o;
        prev_pc    = bus.id_pc_o;
        prev_instr = bus.id_instr_o;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.stall_i    = 1'b0;
        bus.redirect_i = 1'b0;
        bus.target_i   = '0;
        bus.trap_i     = 1'b0;
        bus.trap_vec_i = '0;
        bus.uret_i     = 1'b0;
        bus.epc_i      = '0;
        bus.halt_i     = 1'b0;
        bus.resume_i   = 1'b0;
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.instr = rom_word(exp_pc);
            e.pc    = exp_pc;
            exp_q.push_back(e);
            tick();
            exp_pc = exp_pc + 16'd4;
            chk("pc_seq", 32'(bus.pc_o), 32'(exp_pc));
        end
    endtask

    task automatic chk_bubble(input string name);
        chk({name, "_valid"}, 32'(bus.id_valid_o), 32'd0);
        chk({name, "_instr"}, bus.id_instr_o, 32'h0000_0013);
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        tick();
        tick();
        chk("rst_pc", 32'(bus.pc_o), 32'h0);
        chk_bubble("rst");
        chk("rst_id_pc", 32'(bus.id_pc_o), 32'h0);
        chk("rst_halted", 32'(bus.halted_o), 32'd0);
        chk("rst_misalign", 32'(bus.misalign_o), 32'd0);
        chk("rst_bad_addr", 32'(bus.bad_addr_o), 32'h0);

        rst = 1'b0;
        tick();
        chk("boot_pc", 32'(bus.pc_o), 32'h0);
        chk("boot_valid", 32'(bus.id_valid_o), 32'd0);
        exp_pc = 16'h0000;
        run(2);

        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", 32'(bus.pc_o), 32'h8);
            chk("stall_id_pc", 32'(bus.id_pc_o), 32'h4);
            chk("stall_valid", 32'(bus.id_valid_o), 32'd1);
        end
        bus.stall_i = 1'b0;
        run(1);

        bus.stall_i    = 1'b1;
        bus.redirect_i = 1'b1;
        bus.target_i   = 16'd20;
        tick();
        clear_in();
        chk("redir_pc", 32'(bus.pc_o), 32'd20);
        chk_bubble("redir");
        exp_pc = 16'd20;
        run(1);

        bus.halt_i = 1'b1;
        tick();
        bus.halt_i = 1'b0;
        chk("halt_flag", 32'(bus.halted_o), 32'd1);
        chk("halt_pc", 32'(bus.pc_o), 32'h18);
        chk("halt_valid", 32'(bus.id_valid_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("halt_hold_pc", 32'(bus.pc_o), 32'h18);
            chk("halt_hold_flag", 32'(bus.halted_o), 32'd1);
        end
        bus.resume_i = 1'b1;
        exp_q.push_back('{instr: rom_word(16'h18), pc: 16'h18});
        tick();
        bus.resume_i = 1'b0;
        chk("resume_pc", 32'(bus.pc_o), 32'h1C);
        chk("resume_flag", 32'(bus.halted_o), 32'd0);

        bus.trap_i     = 1'b1;
        bus.trap_vec_i = 16'h0100;
        bus.uret_i     = 1'b1;
        bus.epc_i      = 16'h0010;
        tick();
        clear_in();
        chk("trap_uret_pc", 32'(bus.pc_o), 32'h100);
        chk_bubble("trap_uret");
        exp_pc = 16'h0100;
        run(1);

        bus.uret_i = 1'b1;
        bus.epc_i  = 16'h0010;
        tick();
        clear_in();
        chk("uret_pc", 32'(bus.pc_o), 32'h10);
        chk_bubble("uret");
        exp_pc = 16'h0010;
        run(1);

        bus.halt_i = 1'b1;
        tick();
        clear_in();
        bus.trap_i     = 1'b1;
        bus.trap_vec_i = 16'h0200;
        tick();
        clear_in();
        chk("halt_trap_pc", 32'(bus.pc_o), 32'h200);
        chk("halt_trap_flag", 32'(bus.halted_o), 32'd0);
        exp_pc = 16'h0200;
        run(1);

        bus.redirect_i = 1'b1;
        bus.target_i   = 16'h0022;
        tick();
        clear_in();
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misalign_pc", 32'(bus.pc_o), 32'h204);
        chk("misalign_flag", 32'(bus.misalign_o), 32'd1);
        chk("misalign_addr", 32'(bus.bad_addr_o), 32'h22);
`else
        chk("misalign_pc", 32'(bus.pc_o), 32'h20);
        chk("misalign_flag", 32'(bus.misalign_o), 32'd0);
        chk("misalign_addr", 32'(bus.bad_addr_o), 32'h0);
`endif
        chk("misalign_valid", 32'(bus.id_valid_o), 32'd0);
        bus.trap_i     = 1'b1;
        bus.trap_vec_i = 16'h0300;
        tick();
        clear_in();
        chk("misalign_trap_pc", 32'(bus.pc_o), 32'h300);
        chk("misalign_clear", 32'(bus.misalign_o), 32'd0);

        bus.redirect_i = 1'b1;
        bus.target_i   = 16'hFFF8;
        tick();
        clear_in();
        chk("wrap_redir_pc", 32'(bus.pc_o), 32'hFFF8);
        exp_pc = 16'hFFF8;
        run(3);

        rst            = 1'b1;
        bus.trap_i     = 1'b1;
        bus.trap_vec_i = 16'h0400;
        bus.redirect_i = 1'b1;
        bus.target_i   = 16'h0040;
        tick();
        clear_in();
        rst = 1'b0;
        chk("mid_rst_pc", 32'(bus.pc_o), 32'h0);
        chk_bubble("mid_rst");
        tick();
        chk("mid_rst_boot_pc", 32'(bus.pc_o), 32'h0);
        exp_pc = 16'h0000;
        run(2);

        bus.stall_i = 1'b1;
        tick();
        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
